// File: rtl/dmem_arbiter_mc_pkg.sv
// Shared constants and helpers for the multicore data-memory arbiter.
package dmem_arb_pkg;

   localparam int unsigned ARB_RR    = 0;
   localparam int unsigned ARB_FIXED = 1;
   localparam int unsigned MAX_CORES = 16;
   localparam int unsigned IDX_W     = 4;

   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // OR-reduce bit positions; exact for a one-hot or all-zero vector.
   function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_CORES-1:0] oh);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_CORES; i++) begin
         if (oh[i]) idx = idx | IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/dmem_arbiter_mc_if.sv
// Request, return and memory-side signals of the shared data-memory port.
interface dmem_arbiter_mc_if #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 16
);
   logic                        host_en;
   logic                        host_we;
   logic [ADDR_W-1:0]           host_addr;
   logic [DATA_W-1:0]           host_wdata;
   logic                        host_rvalid;
   logic [NUM_CORES-1:0]        core_req;
   logic [NUM_CORES-1:0]        core_we;
   logic [NUM_CORES*ADDR_W-1:0] core_addr;
   logic [NUM_CORES*DATA_W-1:0] core_wdata;
   logic [NUM_CORES-1:0]        core_gnt;
   logic [NUM_CORES-1:0]        core_rvalid;
   logic [DATA_W-1:0]           mem_rdata_q;
   logic                        mem_we;
   logic                        mem_re;
   logic [ADDR_W-1:0]           mem_addr;
   logic [DATA_W-1:0]           mem_wdata;
   logic [DATA_W-1:0]           mem_rdata;

   // Arbiter side
   modport slave (
      input  host_en, host_we, host_addr, host_wdata,
      input  core_req, core_we, core_addr, core_wdata,
      input  mem_rdata,
      output host_rvalid, core_gnt, core_rvalid, mem_rdata_q,
      output mem_we, mem_re, mem_addr, mem_wdata
   );

   // Requesters and memory side
   modport master (
      output host_en, host_we, host_addr, host_wdata,
      output core_req, core_we, core_addr, core_wdata,
      output mem_rdata,
      input  host_rvalid, core_gnt, core_rvalid, mem_rdata_q,
      input  mem_we, mem_re, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dmem_arbiter_mc_rr_arbiter.sv
// Core grant selection: round-robin from rr_ptr, or fixed lowest-index priority.
module rr_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned N    = 4,
   parameter int unsigned MODE = ARB_RR
) (
   input  logic         clk,
   input  logic         RESET,
   input  logic         en,
   input  logic [N-1:0] req,
   output logic [N-1:0] gnt
);
   localparam int unsigned PW = clog2_min1(N);

   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] rr_ptr_nxt;
   logic [PW-1:0] gnt_idx;

   // First requester at or after the start point, wrapping past N-1.
   always_comb begin
      logic          found;
      logic [PW-1:0] start;
      logic [PW-1:0] kk;
      int unsigned   k;
      gnt   = '0;
      found = 1'b0;
      start = (MODE == ARB_FIXED) ? '0 : rr_ptr;
      kk    = '0;
      k     = 0;
      for (int unsigned i = 0; i < N; i++) begin
         k = 32'(start) + i;
         if (k >= N) k = k - N;
         kk = PW'(k);
         if (!found && en && req[kk]) begin
            gnt[kk] = 1'b1;
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      rr_ptr_nxt = rr_ptr;
      gnt_idx    = PW'(onehot_to_idx(MAX_CORES'(gnt)));
      if (MODE == ARB_RR && (|gnt)) begin
         rr_ptr_nxt = (gnt_idx == PW'(N - 1)) ? '0 : gnt_idx + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (RESET) rr_ptr <= '0;
      else       rr_ptr <= rr_ptr_nxt;
   end

endmodule

// File: rtl/dmem_arbiter_mc.sv
// Arbitrates NUM_CORES cores plus a host onto one single-port synchronous
// data memory and returns tagged read data one cycle after the grant.
module dmem_arbiter_mc
   import dmem_arb_pkg::*;
#(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ADDR_W    = 16,
   parameter int unsigned ARB_MODE  = ARB_RR
) (
   input  logic               clk,
   input  logic               RESET,
   dmem_arbiter_mc_if.slave   bus
);
   localparam int unsigned CW = clog2_min1(NUM_CORES);

   logic [NUM_CORES-1:0] gnt;
   logic [CW-1:0]        g_idx;
   logic                 arb_en;
   logic [NUM_CORES-1:0] rd_tag_q;
   logic                 host_rd_q;
   logic [DATA_W-1:0]    rdata_hold;
   logic                 rvalid_any;

   assign arb_en = ~bus.host_en & ~RESET;

   rr_arbiter #(
      .N    (NUM_CORES),
      .MODE (ARB_MODE)
   ) u_rr_arbiter (
      .clk   (clk),
      .RESET (RESET),
      .en    (arb_en),
      .req   (bus.core_req),
      .gnt   (gnt)
   );

   assign bus.core_gnt = gnt;

   // Memory port mux: host overrides cores, idle drives zeros.
   always_comb begin
      bus.mem_we    = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      g_idx         = CW'(onehot_to_idx(MAX_CORES'(gnt)));
      if (!RESET) begin
         if (bus.host_en) begin
            bus.mem_we    = bus.host_we;
            bus.mem_re    = ~bus.host_we;
            bus.mem_addr  = bus.host_addr;
            bus.mem_wdata = bus.host_wdata;
         end else if (|gnt) begin
            bus.mem_we    = bus.core_we[g_idx];
            bus.mem_re    = ~bus.core_we[g_idx];
            bus.mem_addr  = bus.core_addr[g_idx*ADDR_W +: ADDR_W];
            bus.mem_wdata = bus.core_wdata[g_idx*DATA_W +: DATA_W];
         end
      end
   end

   // Read-return tags; gnt is already zero while the host owns the port.
   always_ff @(posedge clk) begin
      if (RESET) begin
         rd_tag_q   <= '0;
         host_rd_q  <= 1'b0;
         rdata_hold <= '0;
      end else begin
         rd_tag_q  <= gnt & ~bus.core_we;
         host_rd_q <= bus.host_en & ~bus.host_we;
         if (rvalid_any) rdata_hold <= bus.mem_rdata;
      end
   end

   assign rvalid_any      = host_rd_q | (|rd_tag_q);
   assign bus.core_rvalid = rd_tag_q;
   assign bus.host_rvalid = host_rd_q;
   // Memory data arrives in the rvalid cycle itself, so it bypasses the hold register then.
   assign bus.mem_rdata_q = rvalid_any ? bus.mem_rdata : rdata_hold;

endmodule

// File: tb/tb_dmem_arbiter_mc.sv
// Bench for dmem_arbiter_mc: directed tables, corner sequences and random traffic
// against a behavioural reference model (round-robin and fixed-priority instances).
module tb_dmem_arbiter_mc;
   import dmem_arb_pkg::*;

   localparam int unsigned NC = 4;
   localparam int unsigned DW = 16;
   localparam int unsigned AW = 16;

   logic clk = 1'b0;
   logic RESET = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_mc_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) rr_if ();
   dmem_arbiter_mc_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) fp_if ();

   dmem_arbiter_mc #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW), .ARB_MODE(ARB_RR)) u_rr (
      .clk(clk), .RESET(RESET), .bus(rr_if.slave));
   dmem_arbiter_mc #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW), .ARB_MODE(ARB_FIXED)) u_fp (
      .clk(clk), .RESET(RESET), .bus(fp_if.slave));

   // Synchronous single-port memories behind each instance
   bit [DW-1:0] mem_rr [0:65535];
   bit [DW-1:0] mem_fp [0:65535];
   always @(posedge clk) begin
      if (rr_if.mem_we) mem_rr[rr_if.mem_addr] <= rr_if.mem_wdata;
      if (rr_if.mem_re) rr_if.mem_rdata <= mem_rr[rr_if.mem_addr];
   end
   always @(posedge clk) begin
      if (fp_if.mem_we) mem_fp[fp_if.mem_addr] <= fp_if.mem_wdata;
      if (fp_if.mem_re) fp_if.mem_rdata <= mem_fp[fp_if.mem_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus for the round-robin instance
   logic              rst;
   logic              h_en, h_we;
   logic [AW-1:0]     h_addr;
   logic [DW-1:0]     h_wdata;
   logic [NC-1:0]     c_req, c_we;
   logic [NC*AW-1:0]  c_addr;
   logic [NC*DW-1:0]  c_wdata;

   // Reference model state
   int            m_ptr;
   int            m_win;
   bit [DW-1:0]   ref_mem [0:65535];
   logic [NC-1:0] e_crv;
   logic          e_hrv;
   logic [DW-1:0] e_rdq;

   // Winner = requester with the smallest circular distance from ptr (or lowest index).
   function automatic int pick(input logic [NC-1:0] req, input int ptr, input bit fixed);
      int best;
      int bestd;
      int d;
      best  = -1;
      bestd = int'(NC);
      for (int k = 0; k < int'(NC); k++) begin
         if (req[k]) begin
            d = fixed ? k : (k - ptr + int'(NC)) % int'(NC);
            if (d < bestd) begin
               bestd = d;
               best  = k;
            end
         end
      end
      return best;
   endfunction

   task automatic model_reset();
      m_ptr = 0;
      e_crv = '0;
      e_hrv = 1'b0;
      e_rdq = '0;
   endtask

   // One cycle on the round-robin instance: drive, compare, advance the model.
   task automatic apply_rr(input string tag);
      logic [NC-1:0] eg;
      logic          ewe, ere;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      @(negedge clk);
      RESET            = rst;
      rr_if.host_en    = h_en;
      rr_if.host_we    = h_we;
      rr_if.host_addr  = h_addr;
      rr_if.host_wdata = h_wdata;
      rr_if.core_req   = c_req;
      rr_if.core_we    = c_we;
      rr_if.core_addr  = c_addr;
      rr_if.core_wdata = c_wdata;
      #1;
      eg = '0; ewe = 1'b0; ere = 1'b0; ea = '0; ed = '0; m_win = -1;
      if (!rst) begin
         if (h_en) begin
            ewe = h_we; ere = !h_we; ea = h_addr; ed = h_wdata;
         end else begin
            m_win = pick(c_req, m_ptr, 1'b0);
            if (m_win >= 0) begin
               eg[m_win] = 1'b1;
               ewe = c_we[m_win];
               ere = !c_we[m_win];
               ea  = c_addr[m_win*int'(AW) +: AW];
               ed  = c_wdata[m_win*int'(DW) +: DW];
            end
         end
      end
      check({tag, ".gnt"},         32'(rr_if.core_gnt),    32'(eg));
      check({tag, ".mem_we"},      32'(rr_if.mem_we),      32'(ewe));
      check({tag, ".mem_re"},      32'(rr_if.mem_re),      32'(ere));
      check({tag, ".mem_addr"},    32'(rr_if.mem_addr),    32'(ea));
      check({tag, ".mem_wdata"},   32'(rr_if.mem_wdata),   32'(ed));
      check({tag, ".core_rvalid"}, 32'(rr_if.core_rvalid), 32'(e_crv));
      check({tag, ".host_rvalid"}, 32'(rr_if.host_rvalid), 32'(e_hrv));
      check({tag, ".mem_rdata_q"}, 32'(rr_if.mem_rdata_q), 32'(e_rdq));
      if (rst) begin
         model_reset();
      end else begin
         e_crv = '0;
         e_hrv = 1'b0;
         if (ere) begin
            e_rdq = ref_mem[ea];
            if (h_en) e_hrv = 1'b1;
            else      e_crv[m_win] = 1'b1;
         end
         if (ewe) ref_mem[ea] = ed;
         if (m_win >= 0) m_ptr = (m_win + 1) % int'(NC);
      end
   endtask

   task automatic set_core(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      c_we[k] = we;
      c_addr[k*int'(AW) +: AW]  = a;
      c_wdata[k*int'(DW) +: DW] = d;
   endtask

   typedef struct {
      logic [NC-1:0] req;
      logic [NC-1:0] exp_gnt;
   } vec_t;

   vec_t rr_tab [8];
   vec_t fp_tab [10];

   logic [NC-1:0] pend;

   initial begin
      rr_tab[0] = '{4'b1111, 4'b0001}; rr_tab[1] = '{4'b1111, 4'b0010};
      rr_tab[2] = '{4'b1111, 4'b0100}; rr_tab[3] = '{4'b1111, 4'b1000};
      rr_tab[4] = '{4'b1111, 4'b0001}; rr_tab[5] = '{4'b1111, 4'b0010};
      rr_tab[6] = '{4'b1111, 4'b0100}; rr_tab[7] = '{4'b1111, 4'b1000};
      fp_tab[0] = '{4'b1010, 4'b0010}; fp_tab[1] = '{4'b1010, 4'b0010};
      fp_tab[2] = '{4'b1010, 4'b0010}; fp_tab[3] = '{4'b1010, 4'b0010};
      fp_tab[4] = '{4'b1000, 4'b1000}; fp_tab[5] = '{4'b1111, 4'b0001};
      fp_tab[6] = '{4'b0110, 4'b0010}; fp_tab[7] = '{4'b1100, 4'b0100};
      fp_tab[8] = '{4'b0000, 4'b0000}; fp_tab[9] = '{4'b1010, 4'b0010};

      fp_if.host_en = 1'b0; fp_if.host_we = 1'b0; fp_if.host_addr = '0; fp_if.host_wdata = '0;
      fp_if.core_req = '0; fp_if.core_we = '0; fp_if.core_addr = '0; fp_if.core_wdata = '0;

      rst = 1'b1; h_en = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
      c_req = 4'b1111; c_we = '0; c_addr = '0; c_wdata = '0;
      model_reset();

      // Reset: requests are ignored, all returns zero
      apply_rr("reset0");
      apply_rr("reset1");
      rst = 1'b0;

      // Host load then readback while cores request
      h_en = 1'b1; h_we = 1'b1; h_addr = 16'h0010; h_wdata = 16'h00A5;
      apply_rr("host_wr0");
      h_addr = 16'h0011; h_wdata = 16'h1234;
      apply_rr("host_wr1");
      h_we = 1'b0; h_addr = 16'h0010; h_wdata = '0;
      apply_rr("host_rd");
      h_en = 1'b0; c_req = '0;
      apply_rr("host_ret");
      check("host_rvalid", 32'(rr_if.host_rvalid), 32'd1);
      check("host_rdata",  32'(rr_if.mem_rdata_q), 32'h00A5);

      // Round-robin fairness, all cores writing
      for (int k = 0; k < int'(NC); k++) set_core(k, 1'b1, AW'(16'h0020 + k), DW'(16'hC000 + k));
      for (int i = 0; i < 8; i++) begin
         c_req = rr_tab[i].req;
         apply_rr("rr_tab");
         check($sformatf("rr_seq[%0d]", i), 32'(rr_if.core_gnt), 32'(rr_tab[i].exp_gnt));
      end

      // Read tagging: core 2 reads preloaded 0x0011
      c_req = 4'b0100; set_core(2, 1'b0, 16'h0011, 16'h0);
      apply_rr("tag_issue");
      check("tag_gnt", 32'(rr_if.core_gnt), 32'b0100);
      c_req = '0;
      apply_rr("tag_ret");
      check("tag_rvalid", 32'(rr_if.core_rvalid), 32'b0100);
      check("tag_rdata",  32'(rr_if.mem_rdata_q), 32'h1234);

      // Single requester granted every cycle
      set_core(2, 1'b1, 16'h0030, 16'h5555);
      for (int i = 0; i < 3; i++) begin
         c_req = 4'b0100;
         apply_rr("single");
         check("single_gnt", 32'(rr_if.core_gnt), 32'b0100);
      end

      // Host preemption with a core read in flight and rr_ptr = 1
      c_req = 4'b0001; set_core(0, 1'b0, 16'h0010, 16'h0);
      apply_rr("pre_rd");
      c_req = 4'b0011; set_core(0, 1'b1, 16'h0040, 16'hAAAA); set_core(1, 1'b1, 16'h0041, 16'hBBBB);
      h_en = 1'b1; h_we = 1'b0; h_addr = 16'h0011;
      apply_rr("preempt0");
      check("preempt0_gnt",    32'(rr_if.core_gnt),    32'd0);
      check("preempt0_rvalid", 32'(rr_if.core_rvalid), 32'b0001);
      apply_rr("preempt1");
      check("preempt1_gnt", 32'(rr_if.core_gnt), 32'd0);
      h_en = 1'b0;
      apply_rr("preempt_end");
      check("preempt_first", 32'(rr_if.core_gnt), 32'b0010);
      c_req = 4'b0001;
      apply_rr("preempt_next");
      c_req = '0;
      apply_rr("idle");

      // Reset mid-read: core-0 read granted, RESET rises before the edge
      c_req = 4'b0001; set_core(0, 1'b0, 16'h0010, 16'h0);
      apply_rr("rst_rd");
      check("rst_rd_gnt", 32'(rr_if.core_gnt), 32'b0001);
      rst = 1'b1; RESET = 1'b1;
      #1;
      check("rst_gnt_forced", 32'(rr_if.core_gnt), 32'd0);
      model_reset();
      rst = 1'b0; c_req = 4'b1111;
      for (int k = 0; k < int'(NC); k++) set_core(k, 1'b1, AW'(16'h0050 + k), DW'(16'hD000 + k));
      apply_rr("rst_after");
      check("rst_rvalid_dropped", 32'(rr_if.core_rvalid), 32'd0);
      check("rst_first_gnt",      32'(rr_if.core_gnt),    32'b0001);

      // Fixed priority instance
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         fp_if.core_req = fp_tab[i].req;
         #1;
         check($sformatf("fp_gnt[%0d]", i), 32'(fp_if.core_gnt), 32'(fp_tab[i].exp_gnt));
      end
      @(negedge clk);
      fp_if.core_req = '0;

      // Random traffic: cores hold a request until granted
      pend = '0;
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < int'(NC); k++) begin
            if (!pend[k] && ($urandom_range(0, 1) == 1)) begin
               pend[k] = 1'b1;
               set_core(k, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
            end
         end
         c_req   = pend;
         h_en    = ($urandom_range(0, 9) == 0);
         h_we    = 1'($urandom_range(0, 1));
         h_addr  = AW'($urandom_range(0, 31));
         h_wdata = DW'($urandom);
         apply_rr("rand");
         if (m_win >= 0) pend[m_win] = 1'b0;
      end
      h_en = 1'b0; c_req = '0;
      apply_rr("drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
